// File: rtl/rah_tx_packer_if.sv
// ---------------------------------------------------------------------------
// rah_tx_packer_if
// Purpose : valid/ready stream bundle with an end-of-burst marker. It is used
//           for the 48-bit packet input and for the 64-bit word output of
//           the RAH TX packer.
// Signals : valid - data/last are valid this cycle
//           ready - the sink accepts the transfer this cycle
//           data  - payload, W bits wide
//           last  - final transfer of the burst
// Modports: master - stream source (drives valid/data/last)
//           slave  - stream sink (drives ready)
// ---------------------------------------------------------------------------
interface rah_tx_packer_if #(
  parameter int W = 48
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/rah_tx_packer.sv
// ---------------------------------------------------------------------------
// rah_tx_packer
// Purpose : TX-side gearbox. It packs 48-bit RAH packets into a gap-free,
//           LSB-first stream of 64-bit MIPI TX words. Packet k occupies
//           stream bits [48k+47:48k], and word j carries stream bits
//           [64j+63:64j]. When a packet marked last is accepted, the
//           residue is flushed as a zero-padded final word that carries
//           out_last.
// Ports   : clk        - tx_pixel_clk
//           rst        - asynchronous assert, active high
//           in_if      - slave stream of IN_WIDTH-bit packets
//                        (valid/ready/data/last)
//           out_if     - master stream of OUT_WIDTH-bit words
//                        (valid/ready/data/last)
//           fill_level - number of buffered bits divided by UNIT (debug)
//           busy       - data is buffered or a flush is pending
// ---------------------------------------------------------------------------
module rah_tx_packer #(
  parameter int IN_WIDTH  = 48,
  parameter int OUT_WIDTH = 64,
  parameter int UNIT      = 16,
  parameter int BUF_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  rah_tx_packer_if.slave         in_if,
  rah_tx_packer_if.master        out_if,
  output logic [7:0]             fill_level,
  output logic                   busy
);

  localparam int FILL_W = $clog2(BUF_WIDTH + 1);

  localparam logic [FILL_W-1:0] IN_BITS   = FILL_W'(IN_WIDTH);
  localparam logic [FILL_W-1:0] OUT_BITS  = FILL_W'(OUT_WIDTH);
  localparam logic [FILL_W-1:0] IN_LIMIT  = FILL_W'(BUF_WIDTH - IN_WIDTH);
  localparam logic [FILL_W-1:0] UNIT_BITS = FILL_W'(UNIT);
  localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};

  // Buffer bits at or above fill_r are always zero. Because of this, the
  // final word is padded automatically and new packets can be OR-ed in.
  logic [BUF_WIDTH-1:0] buf_r;
  logic [FILL_W-1:0]    fill_r;
  logic                 flush_pend_r;

  logic [BUF_WIDTH-1:0] buf_shift_s;
  logic [BUF_WIDTH-1:0] buf_next_s;
  logic [BUF_WIDTH-1:0] in_ext_s;
  logic [FILL_W-1:0]    fill_shift_s;
  logic [FILL_W-1:0]    fill_next_s;
  logic                 flush_next_s;
  logic                 in_ready_s;
  logic                 out_valid_s;
  logic                 out_last_s;
  logic                 accept_s;
  logic                 emit_s;

  // Decode the handshake outputs from the state registers. Only in_ready
  // also sees rst, so that it stays low for the whole time reset is held.
  always_comb begin
    in_ready_s  = !rst && !flush_pend_r && (fill_r <= IN_LIMIT);
    out_valid_s = (fill_r >= OUT_BITS) || (flush_pend_r && (fill_r != FILL_ZERO));
    out_last_s  = out_valid_s && flush_pend_r && (fill_r <= OUT_BITS);
    accept_s    = in_if.valid && in_ready_s;
    emit_s      = out_valid_s && out_if.ready;
  end

  assign in_if.ready  = in_ready_s;
  assign out_if.valid = out_valid_s;
  assign out_if.data  = buf_r[OUT_WIDTH-1:0];
  assign out_if.last  = out_last_s;
  assign fill_level   = 8'(fill_r / UNIT_BITS);
  assign busy         = (fill_r != FILL_ZERO) || flush_pend_r;

  // Compute the next state. An outgoing word is shifted out first, and an
  // incoming packet is then written at the fill level that remains.
  always_comb begin
    buf_shift_s  = buf_r;
    fill_shift_s = fill_r;
    if (emit_s) begin
      buf_shift_s  = buf_r >> OUT_WIDTH;
      fill_shift_s = (fill_r >= OUT_BITS) ? (fill_r - OUT_BITS) : FILL_ZERO;
    end else begin
      buf_shift_s  = buf_r;
      fill_shift_s = fill_r;
    end

    // in_ready limits fill to at most BUF_WIDTH-IN_WIDTH, so no packet bits
    // are ever lost off the top of the buffer.
    in_ext_s = BUF_WIDTH'(in_if.data) << fill_shift_s;

    if (accept_s) begin
      buf_next_s  = buf_shift_s | in_ext_s;
      fill_next_s = fill_shift_s + IN_BITS;
    end else begin
      buf_next_s  = buf_shift_s;
      fill_next_s = fill_shift_s;
    end

    // A flush can only start while none is pending, and it can only end
    // while one is pending, so these two cases never occur together.
    if (accept_s && in_if.last) begin
      flush_next_s = 1'b1;
    end else if (emit_s && out_last_s) begin
      flush_next_s = 1'b0;
    end else begin
      flush_next_s = flush_pend_r;
    end
  end

  // State registers. Reset discards any residue and any pending flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r        <= {BUF_WIDTH{1'b0}};
      fill_r       <= FILL_ZERO;
      flush_pend_r <= 1'b0;
    end else begin
      buf_r        <= buf_next_s;
      fill_r       <= fill_next_s;
      flush_pend_r <= flush_next_s;
    end
  end

endmodule

// File: tb/tb_rah_tx_packer.sv
// ---------------------------------------------------------------------------
// tb_rah_tx_packer
// Purpose : self-checking bench for rah_tx_packer. It applies directed
//           vector tables, hand-written corner sequences, and a randomized
//           run that is checked against a bit-queue stream model.
// ---------------------------------------------------------------------------
module tb_rah_tx_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] fill_level;
  logic       busy;

  always #5 clk = ~clk;

  rah_tx_packer_if #(.W(48)) in_if ();
  rah_tx_packer_if #(.W(64)) out_if ();

  rah_tx_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (in_if),
    .out_if     (out_if),
    .fill_level (fill_level),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model: stream as a queue of bits ------------
  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } word_t;

  bit    bitq[$];
  word_t exp_q[$];

  int          words_seen;
  int          lasts_seen;
  int          last_word_idx;
  logic        hold_prev;
  logic [63:0] hold_data;
  logic        hold_last;

  task automatic model_reset();
    bitq.delete();
    exp_q.delete();
    hold_prev     = 1'b0;
    words_seen    = 0;
    lasts_seen    = 0;
    last_word_idx = 0;
  endtask

  // Append a packet to the stream. Every full 64 bits becomes a word. A
  // last packet also flushes the remainder as a zero-padded final word.
  task automatic model_accept(input logic [47:0] d, input logic il);
    word_t w;
    for (int i = 0; i < 48; i++) bitq.push_back(d[i]);
    while (bitq.size() >= 64 || (il && bitq.size() > 0)) begin
      w.d = 64'd0;
      for (int i = 0; i < 64; i++) begin
        if (bitq.size() > 0) w.d[i] = bitq.pop_front();
      end
      w.l = il && (bitq.size() == 0);
      exp_q.push_back(w);
    end
  endtask

  // Run one cycle. The call starts and ends at a negedge. Inputs are
  // applied, outputs are sampled 1 ns later, the transfers are scored, and
  // the task then waits through the posedge.
  task automatic do_cycle(input logic iv, input logic [47:0] d, input logic il,
                          input logic ordy, output logic acc);
    word_t e;
    in_if.valid  = iv;
    in_if.data   = d;
    in_if.last   = il;
    out_if.ready = ordy;
    #1;
    if (hold_prev) begin
      check("hold_valid", 64'(out_if.valid), 64'd1);
      check("hold_data", out_if.data, hold_data);
      check("hold_last", 64'(out_if.last), 64'(hold_last));
    end
    acc = iv && in_if.ready;
    if (out_if.valid && ordy) begin
      words_seen++;
      if (out_if.last) begin
        lasts_seen++;
        last_word_idx = words_seen;
      end
      check("exp_word_available", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("word_data", out_if.data, e.d);
        check("word_last", 64'(out_if.last), 64'(e.l));
      end
    end
    hold_prev = out_if.valid && !ordy;
    hold_data = out_if.data;
    hold_last = out_if.last;
    if (acc) model_accept(d, il);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_pkt(input logic [47:0] d, input logic il, input logic ordy);
    logic acc;
    int   k;
    acc = 1'b0;
    k   = 0;
    while (!acc && k < 50) begin
      do_cycle(1'b1, d, il, ordy, acc);
      k++;
    end
    check("send_accepted", 64'(acc), 64'd1);
    in_if.valid = 1'b0;
  endtask

  task automatic drain();
    logic a;
    int   k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 100) begin
      do_cycle(1'b0, 48'd0, 1'b0, 1'b1, a);
      k++;
    end
    check("drain_idle", 64'(busy), 64'd0);
    check("drain_exp_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    logic        iv;
    logic [47:0] id;
    logic        il;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [63:0] od;
    logic        ol;
    logic [7:0]  lvl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [47:0] id, logic il, logic ordy,
                              logic ir, logic ov, logic [63:0] od, logic ol, logic [7:0] lvl);
    vec_t v;
    v.iv = iv; v.id = id; v.il = il; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.od = od; v.ol = ol; v.lvl = lvl;
    return v;
  endfunction

  initial begin
    logic        a;
    logic [47:0] rd;

    // Pack: packets 1..4 back-to-back, out_ready held high.
    tbl.push_back(mk(1'b1, 48'h1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 48'h2, 1'b0, 1'b1, 1'b1, 1'b0, 64'h1, 1'b0, 8'd3));
    tbl.push_back(mk(1'b1, 48'h3, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0002_0000_0000_0001, 1'b0, 8'd6));
    tbl.push_back(mk(1'b1, 48'h3, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 8'd2));
    tbl.push_back(mk(1'b1, 48'h4, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0003_0000_0000, 1'b0, 8'd5));
    tbl.push_back(mk(1'b0, 48'h0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0004_0000, 1'b0, 8'd4));
    tbl.push_back(mk(1'b0, 48'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 8'd0));
    // Flush: a single packet marked last, the word is held once, then taken.
    tbl.push_back(mk(1'b1, 48'hABCD_EF01_2345, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_ABCD_EF01_2345, 1'b1, 8'd3));
    tbl.push_back(mk(1'b0, 48'h0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0000_ABCD_EF01_2345, 1'b1, 8'd3));
    tbl.push_back(mk(1'b0, 48'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 8'd0));
    // Backpressure: two packets fill the buffer to 96 bits, then release.
    tbl.push_back(mk(1'b1, 48'h1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 48'h2, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1, 1'b0, 8'd3));
    tbl.push_back(mk(1'b1, 48'h3, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0002_0000_0000_0001, 1'b0, 8'd6));
    tbl.push_back(mk(1'b1, 48'h3, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0002_0000_0000_0001, 1'b0, 8'd6));
    tbl.push_back(mk(1'b1, 48'h3, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0002_0000_0000_0001, 1'b0, 8'd6));
    tbl.push_back(mk(1'b1, 48'h3, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 8'd2));
    tbl.push_back(mk(1'b1, 48'h4, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0003_0000_0000, 1'b0, 8'd5));
    tbl.push_back(mk(1'b0, 48'h0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0004_0000, 1'b0, 8'd4));
    tbl.push_back(mk(1'b0, 48'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 8'd0));

    // Reset state.
    rst          = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = 48'd0;
    in_if.last   = 1'b0;
    out_if.ready = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_if.ready), 64'd0);
    check("rst_out_valid", 64'(out_if.valid), 64'd0);
    check("rst_out_last", 64'(out_if.last), 64'd0);
    check("rst_out_data", out_if.data, 64'd0);
    check("rst_fill_level", 64'(fill_level), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1;
    check("release_in_ready", 64'(in_if.ready), 64'd1);
    @(negedge clk);

    // Apply the directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      in_if.valid  = tbl[i].iv;
      in_if.data   = tbl[i].id;
      in_if.last   = tbl[i].il;
      out_if.ready = tbl[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), 64'(in_if.ready), 64'(tbl[i].ir));
      check($sformatf("v%0d_out_valid", i), 64'(out_if.valid), 64'(tbl[i].ov));
      check($sformatf("v%0d_out_data", i), out_if.data, tbl[i].od);
      check($sformatf("v%0d_out_last", i), 64'(out_if.last), 64'(tbl[i].ol));
      check($sformatf("v%0d_fill_level", i), 64'(fill_level), 64'(tbl[i].lvl));
      @(posedge clk);
      @(negedge clk);
    end

    // Boundary last: four packets with last on the fourth give exactly three
    // words, and only the third word carries last.
    model_reset();
    send_pkt(48'h1111_2222_3333, 1'b0, 1'b1);
    send_pkt(48'h4444_5555_6666, 1'b0, 1'b1);
    send_pkt(48'h7777_8888_9999, 1'b0, 1'b1);
    send_pkt(48'hAAAA_BBBB_CCCC, 1'b1, 1'b1);
    drain();
    check("bnd_words", 64'(words_seen), 64'd3);
    check("bnd_lasts", 64'(lasts_seen), 64'd1);
    check("bnd_last_idx", 64'(last_word_idx), 64'd3);
    #1;
    check("bnd_in_ready_after", 64'(in_if.ready), 64'd1);
    @(negedge clk);

    // Reset mid-burst.
    model_reset();
    send_pkt(48'h1, 1'b0, 1'b1);
    send_pkt(48'h2, 1'b0, 1'b1);
    send_pkt(48'h3, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_if.valid), 64'd0);
    check("midrst_fill_level", 64'(fill_level), 64'd0);
    check("midrst_in_ready", 64'(in_if.ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("postrst_out_valid", 64'(out_if.valid), 64'd0);
    @(negedge clk);
    send_pkt(48'h7, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("partial_not_emitted", 64'(out_if.valid), 64'd0);
      @(negedge clk);
    end
    send_pkt(48'h0, 1'b1, 1'b1);
    drain();
    check("postrst_words", 64'(words_seen), 64'd2);

    // Randomized run against the stream model.
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      rd = {16'($urandom), 32'($urandom)};
      do_cycle(($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) != 0), a);
    end
    send_pkt({16'($urandom), 32'($urandom)}, 1'b1, 1'b1);
    drain();
    check("rand_fill_level", 64'(fill_level), 64'd0);
    check("rand_bitq_empty", 64'(bitq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
